// File: rtl/traffic_pkg.sv
// Shared lamp encodings, scheduler state enum and interval helper for intersection control.
// Latency: none (definitions only).
// Backpressure: not applicable.
package traffic_pkg;

  typedef logic [1:0] light_t;

  localparam light_t LIGHT_RED    = 2'b00;
  localparam light_t LIGHT_YELLOW = 2'b01;
  localparam light_t LIGHT_GREEN  = 2'b10;

  typedef enum logic [1:0] {ST_ALL_RED, ST_GREEN, ST_YELLOW} state_t;

  // True on the tick that completes an interval lasting dur ticks.
  function automatic logic interval_done(input int timer, input int dur);
    return (timer + 1) >= dur;
  endfunction

endpackage

// File: rtl/rr_phase_picker.sv
// Combinational round-robin picker: first demanding index after last, wrapping, last itself checked last.
// Latency: purely combinational.
// Backpressure: none; valid low when no demand.
module rr_phase_picker #(
  parameter int  N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] demand,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] next
);

  logic [W-1:0] idx;

  always_comb begin
    valid = 1'b0;
    next  = last;
    idx   = last;
    // Scan from the farthest candidate back to the nearest so the nearest hit wins.
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(last) + k) % N);
      if (demand[idx]) begin
        valid = 1'b1;
        next  = idx;
      end
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Demand-actuated round-robin phase scheduler (GREEN/YELLOW/ALL_RED + WALK); EMERGENCY_PREEMPT_EN adds preemption.
// Latency: requests latch 1 clk after assertion; lamps decode registered state directly.
// Backpressure: none; timers advance only on tick and latched requests persist until served or reset.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int  NUM_PHASES   = 4,
  parameter int  MIN_GREEN    = 4,
  parameter int  MAX_GREEN    = 10,
  parameter int  YELLOW_TIME  = 2,
  parameter int  ALL_RED_TIME = 1,
  parameter int  WALK_TIME    = 6,
  parameter int  CNT_W        = 4,
  localparam int PH_W         = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic [NUM_PHASES-1:0]   veh_req,
  input  logic [NUM_PHASES-1:0]   ped_req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic                    preempt_req,
  input  logic [PH_W-1:0]         preempt_phase,
`endif
  output logic [2*NUM_PHASES-1:0] phase_light,
  output logic [NUM_PHASES-1:0]   walk,
  output logic [PH_W-1:0]         cur_phase
);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic [PH_W-1:0]       cur_d;
  logic                  walk_q, walk_d;
  logic [NUM_PHASES-1:0] veh_pend_q, veh_pend_d;
  logic [NUM_PHASES-1:0] ped_pend_q, ped_pend_d;
  logic [NUM_PHASES-1:0] demand, cur_mask;
  logic [NUM_PHASES-1:0] clr_veh, clr_ped, repend_ped;
  logic                  pick_vld;
  logic [PH_W-1:0]       pick_idx;
  logic                  other_demand, walk_done, green_done;
  int                    t;

  assign demand       = veh_pend_q | ped_pend_q;
  assign cur_mask     = NUM_PHASES'(1) << cur_phase;
  assign other_demand = |(demand & ~cur_mask);
  assign t            = int'(timer_q);
  assign walk_done    = !walk_q || interval_done(t, WALK_TIME);
  assign green_done   = interval_done(t, MIN_GREEN) && walk_done && other_demand &&
                        (!veh_req[cur_phase] || interval_done(t, MAX_GREEN));

  rr_phase_picker #(.N(NUM_PHASES)) u_picker (
    .demand (demand),
    .last   (cur_phase),
    .valid  (pick_vld),
    .next   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_phase;
    walk_d     = walk_q;
    clr_veh    = '0;
    clr_ped    = '0;
    repend_ped = '0;
    case (state_q)
      ST_ALL_RED: begin
        if (tick && interval_done(t, ALL_RED_TIME)) begin
`ifdef EMERGENCY_PREEMPT_EN
          if (preempt_req) begin
            state_d = ST_GREEN;
            cur_d   = preempt_phase;
          end else
`endif
          if (pick_vld) begin
            state_d = ST_GREEN;
            cur_d   = pick_idx;
          end
        end
      end
      ST_GREEN: begin
        if (tick) begin
          if (walk_q && interval_done(t, WALK_TIME)) walk_d = 1'b0;
          if (green_done) state_d = ST_YELLOW;
`ifdef EMERGENCY_PREEMPT_EN
          // A cut-short walk is re-queued so the pedestrian is served later.
          if (preempt_req && (cur_phase != preempt_phase)) begin
            state_d = ST_YELLOW;
            if (walk_q) repend_ped = cur_mask;
          end else if (preempt_req) begin
            state_d = ST_GREEN;
          end
`endif
        end
      end
      ST_YELLOW: begin
        if (tick && interval_done(t, YELLOW_TIME)) state_d = ST_ALL_RED;
      end
      default: state_d = ST_ALL_RED;
    endcase

    if (state_d != ST_GREEN) begin
      walk_d = 1'b0;
    end else if (state_q != ST_GREEN) begin
      clr_veh = NUM_PHASES'(1) << cur_d;
      if (ped_pend_q[cur_d]) begin
        walk_d  = 1'b1;
        clr_ped = NUM_PHASES'(1) << cur_d;
      end
    end
  end

  always_comb begin
    veh_pend_d = (veh_req & ~((state_q == ST_GREEN) ? cur_mask : '0)) | (veh_pend_q & ~clr_veh);
    ped_pend_d = (ped_req & ~walk) | (ped_pend_q & ~clr_ped) | repend_ped;
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)
      timer_d = '0;
    else if (tick && (t < MAX_GREEN))
      timer_d = timer_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ALL_RED;
      timer_q    <= '0;
      cur_phase  <= PH_W'(NUM_PHASES - 1);
      walk_q     <= 1'b0;
      veh_pend_q <= '0;
      ped_pend_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cur_phase  <= cur_d;
      walk_q     <= walk_d;
      veh_pend_q <= veh_pend_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  always_comb begin
    phase_light = {NUM_PHASES{LIGHT_RED}};
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (cur_phase == PH_W'(i)) begin
        if (state_q == ST_GREEN)       phase_light[2*i +: 2] = LIGHT_GREEN;
        else if (state_q == ST_YELLOW) phase_light[2*i +: 2] = LIGHT_YELLOW;
      end
    end
  end

  assign walk = walk_q ? cur_mask : '0;

endmodule
